mac_tx_arb: RTL and testbench

//  Round-robin arbiter sharing the single mac_rgmii TX byte interface between N frame

---
 rtl/mac_tx_arb.sv | 191 +++++++++++++++++++
 tb/tb_mac_tx_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arb.sv
// Round-robin arbiter sharing one MAC TX byte interface between N frame sources.
// Forwards the granted source's frame with one register of latency and enforces the inter-frame gap.
module mac_tx_arb #(
    parameter int N       = 3,
    parameter int IFG     = 12,
    parameter int GNT_TMO = 64
) (
    input  logic             mac_tx_clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    input  logic [8*N-1:0]   src_data_i,
    input  logic [N-1:0]     src_valid_i,
    input  logic [N-1:0]     src_sof_i,
    input  logic [N-1:0]     src_eof_i,
    output logic [7:0]       mac_tx_data,
    output logic             mac_tx_valid,
    output logic             mac_tx_sof,
    output logic             mac_tx_eof,
    output logic [2:0]       cur_src_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int TMO_W = $clog2(GNT_TMO + 1);
    localparam int IFG_W = $clog2(IFG + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GNT_TMO - 1);
    localparam logic [IFG_W-1:0] GAP_LOAD = IFG_W'(IFG - 1);

    state_t             state_r;
    logic [2:0]         rr_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [IFG_W-1:0]   gap_cnt_r;

    logic [2*N-1:0]     rot_s;
    logic [3:0]         sum_s;
    logic [2:0]         win_idx_s;
    logic               win_found_s;
    logic               g_req_s;
    logic               g_valid_s;
    logic               g_sof_s;
    logic               g_eof_s;
    logic [7:0]         g_data_s;

    function automatic logic [2:0] next_src(input logic [2:0] cur);
        logic [3:0] inc;
        inc = {1'b0, cur} + 4'd1;
        return (inc >= 4'(N)) ? 3'd0 : inc[2:0];
    endfunction

    function automatic logic [N-1:0] onehot(input logic [2:0] idx);
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            v[i] = (idx == 3'(i));
        end
        return v;
    endfunction

    // Winner search: rotate requests so bit 0 is the source the pointer names, take the first set bit.
    always_comb begin
        rot_s       = {req_i, req_i} >> rr_r;
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        sum_s       = 4'd0;
        for (int i = 0; i < N; i++) begin
            sum_s       = {1'b0, rr_r} + 4'(i);
            sum_s       = (sum_s >= 4'(N)) ? (sum_s - 4'(N)) : sum_s;
            win_idx_s   = (rot_s[i] && !win_found_s) ? sum_s[2:0] : win_idx_s;
            win_found_s = win_found_s | rot_s[i];
        end
    end

    // Grantee view of the source buses; non-grantee lanes are masked off entirely.
    always_comb begin
        g_req_s   = 1'b0;
        g_valid_s = 1'b0;
        g_sof_s   = 1'b0;
        g_eof_s   = 1'b0;
        g_data_s  = 8'h00;
        for (int i = 0; i < N; i++) begin
            g_req_s   = g_req_s   | (req_i[i]       & (cur_src_o == 3'(i)));
            g_valid_s = g_valid_s | (src_valid_i[i] & (cur_src_o == 3'(i)));
            g_sof_s   = g_sof_s   | (src_sof_i[i]   & (cur_src_o == 3'(i)));
            g_eof_s   = g_eof_s   | (src_eof_i[i]   & (cur_src_o == 3'(i)));
            g_data_s  = g_data_s  | (src_data_i[8*i +: 8] & {8{cur_src_o == 3'(i)}});
        end
    end

    // Arbitration FSM and registered MAC-side outputs.
    always_ff @(posedge mac_tx_clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_r         <= 3'd0;
            tmo_cnt_r    <= {TMO_W{1'b0}};
            gap_cnt_r    <= {IFG_W{1'b0}};
            gnt_o        <= {N{1'b0}};
            cur_src_o    <= 3'd0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
            mac_tx_data  <= 8'h00;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
        end else begin
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            err_o        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        state_r   <= ST_GRANT;
                        gnt_o     <= onehot(win_idx_s);
                        cur_src_o <= win_idx_s;
                        busy_o    <= 1'b1;
                        tmo_cnt_r <= {TMO_W{1'b0}};
                    end
                end
                ST_GRANT: begin
                    if (g_valid_s && g_sof_s) begin
                        mac_tx_data  <= g_data_s;
                        mac_tx_valid <= 1'b1;
                        mac_tx_sof   <= 1'b1;
                        mac_tx_eof   <= g_eof_s;
                        if (g_eof_s) begin
                            state_r   <= ST_GAP;
                            gnt_o     <= {N{1'b0}};
                            rr_r      <= next_src(cur_src_o);
                            gap_cnt_r <= GAP_LOAD;
                        end else begin
                            state_r   <= ST_XFER;
                        end
                    end else if (!g_req_s || (tmo_cnt_r == TMO_LAST)) begin
                        // Withdrawn request is a clean give-up; only the timeout is flagged.
                        state_r <= ST_IDLE;
                        gnt_o   <= {N{1'b0}};
                        rr_r    <= next_src(cur_src_o);
                        busy_o  <= 1'b0;
                        err_o   <= g_req_s;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_XFER: begin
                    mac_tx_valid <= 1'b1;
                    if (g_valid_s) begin
                        mac_tx_data <= g_data_s;
                        mac_tx_eof  <= g_eof_s;
                        if (g_eof_s) begin
                            state_r   <= ST_GAP;
                            gnt_o     <= {N{1'b0}};
                            rr_r      <= next_src(cur_src_o);
                            gap_cnt_r <= GAP_LOAD;
                        end
                    end else begin
                        // Source underrun: close the frame with a zero byte so the MAC emits a bad CRC.
                        mac_tx_data <= 8'h00;
                        mac_tx_eof  <= 1'b1;
                        err_o       <= 1'b1;
                        state_r     <= ST_GAP;
                        gnt_o       <= {N{1'b0}};
                        rr_r        <= next_src(cur_src_o);
                        gap_cnt_r   <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == {IFG_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - IFG_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_o   <= {N{1'b0}};
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_arb.sv
// Self-checking bench for mac_tx_arb: directed scenarios plus randomized source traffic,
// checked every cycle against a transaction-level reference model.
module tb_mac_tx_arb;
    localparam int N       = 3;
    localparam int IFG     = 12;
    localparam int GNT_TMO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, gnt, src_valid, src_sof, src_eof;
    logic [8*N-1:0] src_data;
    logic [7:0]     tx_data;
    logic           tx_valid, tx_sof, tx_eof, busy, err;
    logic [2:0]     cur_src;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    mac_tx_arb #(.N(N), .IFG(IFG), .GNT_TMO(GNT_TMO)) dut (
        .mac_tx_clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt),
        .src_data_i(src_data), .src_valid_i(src_valid), .src_sof_i(src_sof), .src_eof_i(src_eof),
        .mac_tx_data(tx_data), .mac_tx_valid(tx_valid), .mac_tx_sof(tx_sof), .mac_tx_eof(tx_eof),
        .cur_src_o(cur_src), .busy_o(busy), .err_o(err)
    );

    // Commands from the test sequence; the source driver latches them on a new sequence number.
    int c_seq[N], c_len[N], c_stall[N], c_abort[N], c_rep[N];
    bit c_nosof[N], c_noise[N];
    int c_clr = 0;

    int s_seq[N], s_pos[N], s_len[N], s_stall[N], s_abort[N], s_rep[N];
    bit s_active[N], s_nosof[N], s_granted[N], s_sent_eof[N];
    int s_clr = 0;

    // Source behaviour: request, wait for grant, stream bytes (with optional stall / no-sof / abort).
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (s_clr != c_clr) s_active[k] = 1'b0;
            if (s_seq[k] != c_seq[k]) begin
                s_seq[k] = c_seq[k];
                s_active[k] = 1'b1; s_pos[k] = 0; s_len[k] = c_len[k]; s_stall[k] = c_stall[k];
                s_nosof[k] = c_nosof[k]; s_abort[k] = c_abort[k]; s_rep[k] = c_rep[k];
                s_granted[k] = 1'b0; s_sent_eof[k] = 1'b0;
            end
            src_valid[k] = 1'b0; src_sof[k] = 1'b0; src_eof[k] = 1'b0;
            if (!s_active[k]) begin
                req[k] = 1'b0;
                if (c_noise[k]) begin
                    src_valid[k] = 1'($urandom); src_sof[k] = 1'($urandom); src_eof[k] = 1'($urandom);
                    src_data[8*k +: 8] = 8'($urandom);
                end
            end else if (s_sent_eof[k]) begin
                if (s_rep[k] > 0) begin
                    s_rep[k]--; s_pos[k] = 0; s_sent_eof[k] = 1'b0; s_granted[k] = 1'b0; req[k] = 1'b1;
                end else begin
                    s_active[k] = 1'b0; req[k] = 1'b0;
                end
            end else if (s_granted[k] && !gnt[k]) begin
                s_active[k] = 1'b0; req[k] = 1'b0;
            end else if (gnt[k]) begin
                s_granted[k] = 1'b1; req[k] = 1'b1;
                if (s_nosof[k]) begin
                    if (s_abort[k] == 1) req[k] = 1'b0;
                    if (s_abort[k] > 0) s_abort[k]--;
                    src_valid[k] = 1'($urandom); src_eof[k] = 1'($urandom);
                    src_data[8*k +: 8] = 8'($urandom);
                end else if (s_pos[k] != s_stall[k]) begin
                    src_valid[k] = 1'b1;
                    src_sof[k] = (s_pos[k] == 0);
                    src_eof[k] = (s_pos[k] == s_len[k] - 1);
                    src_data[8*k +: 8] = 8'(k * 64 + s_pos[k]);
                    if (src_eof[k]) s_sent_eof[k] = 1'b1;
                    s_pos[k]++;
                end
            end else begin
                req[k] = 1'b1;
                if (c_noise[k]) begin
                    src_valid[k] = 1'($urandom); src_sof[k] = 1'($urandom); src_eof[k] = 1'($urandom);
                    src_data[8*k +: 8] = 8'($urandom);
                end
            end
        end
        s_clr = c_clr;
    end

    // Reference model: who owns the link, how long it has waited, and how much gap remains.
    int m_owner, m_rr, m_gap, m_wait, m_k, m_c;
    bit m_started;
    logic [N-1:0] e_gnt;
    logic [2:0]   e_cur;
    logic [7:0]   e_data;
    logic         e_busy, e_valid, e_sof, e_eof, e_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_rr = 0; m_gap = 0; m_wait = 0; m_started = 1'b0;
            e_gnt = '0; e_cur = 3'd0; e_data = 8'h00;
            e_busy = 1'b0; e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_err = 1'b0;
        end else begin
            e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_err = 1'b0;
            if (m_gap > 0) begin
                m_gap--;
                e_busy = (m_gap != 0);
            end else if (m_owner < 0) begin
                for (int i = N - 1; i >= 0; i--) begin
                    m_c = (m_rr + i) % N;
                    if (req[m_c]) m_owner = m_c;
                end
                if (m_owner >= 0) begin
                    e_gnt = '0; e_gnt[m_owner] = 1'b1; e_cur = 3'(m_owner);
                    e_busy = 1'b1; m_wait = 0; m_started = 1'b0;
                end
            end else begin
                m_k = m_owner;
                if (src_valid[m_k] && (src_sof[m_k] || m_started)) begin
                    e_valid = 1'b1; e_sof = !m_started; e_eof = src_eof[m_k];
                    e_data = src_data[8*m_k +: 8];
                    m_started = 1'b1;
                end else if (m_started) begin
                    e_valid = 1'b1; e_eof = 1'b1; e_data = 8'h00; e_err = 1'b1;
                end else begin
                    m_wait++;
                    if (!req[m_k] || m_wait >= GNT_TMO) begin
                        e_err = req[m_k];
                        e_gnt = '0; m_rr = (m_k + 1) % N; m_owner = -1; e_busy = 1'b0;
                    end
                end
                if (e_eof) begin
                    e_gnt = '0; m_rr = (m_k + 1) % N; m_owner = -1; m_gap = IFG;
                end
            end
        end
    end

    int out_data[$], out_flags[$], gnt_log[$], gnt_rise[$], eof_cyc[$];
    int err_cnt = 0, gnt0_cycles = 0;
    logic [N-1:0] prev_gnt = '0;

    // Per-cycle comparison against the model, plus a log for the scenario checks.
    always @(posedge clk) begin
        #1;
        cycle++;
        vectors++;
        if (gnt !== e_gnt || busy !== e_busy || tx_valid !== e_valid || tx_sof !== e_sof ||
            tx_eof !== e_eof || tx_data !== e_data || err !== e_err || (e_busy && cur_src !== e_cur)) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got gnt=%b cur=%0d busy=%b v=%b s=%b e=%b d=%h err=%b, expected gnt=%b cur=%0d busy=%b v=%b s=%b e=%b d=%h err=%b",
                     cycle, gnt, cur_src, busy, tx_valid, tx_sof, tx_eof, tx_data, err,
                     e_gnt, e_cur, e_busy, e_valid, e_sof, e_eof, e_data, e_err);
        end
        if (tx_valid) begin out_data.push_back(int'(tx_data)); out_flags.push_back({tx_sof, tx_eof}); end
        if (tx_valid && tx_eof) eof_cyc.push_back(cycle);
        if (err) err_cnt++;
        if (gnt[0]) gnt0_cycles++;
        if (gnt != '0 && prev_gnt == '0) begin gnt_log.push_back(int'(cur_src)); gnt_rise.push_back(cycle); end
        prev_gnt = gnt;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        out_data.delete(); out_flags.delete(); gnt_log.delete(); gnt_rise.delete(); eof_cyc.delete();
        err_cnt = 0; gnt0_cycles = 0;
    endtask

    task automatic arm(input int k, input int len, input int stall, input bit nosof, input int abrt, input int rep);
        c_len[k] = len; c_stall[k] = stall; c_nosof[k] = nosof; c_abort[k] = abrt; c_rep[k] = rep;
        c_seq[k]++;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1; c_clr++;
        for (int k = 0; k < N; k++) c_noise[k] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(posedge clk); #2;
            idle = !e_busy && !busy;
            for (int k = 0; k < N; k++) if (s_active[k]) idle = 1'b0;
        end
        chk("wait_idle_done", int'(idle), 1);
    endtask

    int bad;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin c_seq[k] = 0; c_noise[k] = 1'b0; end
        do_reset();
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(tx_valid), 0);

        // Single 60-byte frame from source 0.
        arm(0, 60, -1, 1'b0, 0, 0);
        @(posedge clk); #2;
        chk("t1_gnt_after_req", int'(gnt), 1);
        wait_idle(400);
        chk("t1_bytes", out_data.size(), 60);
        bad = 0;
        for (int i = 0; i < out_data.size(); i++) if (out_data[i] != i) bad++;
        chk("t1_data_seq", bad, 0);
        chk("t1_first_sof", out_flags[0], 2);
        chk("t1_last_eof", out_flags[59], 1);
        chk("t1_gnt_clear", int'(gnt), 0);

        // All three request; source 0 comes back for a second frame.
        do_reset();
        arm(0, 10, -1, 1'b0, 0, 1); arm(1, 10, -1, 1'b0, 0, 0); arm(2, 10, -1, 1'b0, 0, 0);
        wait_idle(600);
        chk("t2_frames", gnt_log.size(), 4);
        chk("t2_order0", gnt_log[0], 0); chk("t2_order1", gnt_log[1], 1);
        chk("t2_order2", gnt_log[2], 2); chk("t2_order3", gnt_log[3], 0);
        for (int i = 0; i < 3; i++) chk("t2_ifg", gnt_rise[i+1] - eof_cyc[i], IFG + 1);

        // Source 0 never presents sof; source 1 waits behind it.
        do_reset();
        arm(0, 5, -1, 1'b1, 0, 0); arm(1, 5, -1, 1'b0, 0, 0);
        wait_idle(600);
        chk("t3_gnt0_cycles", gnt0_cycles, 64);
        chk("t3_err_pulses", err_cnt, 1);
        chk("t3_next_grant", gnt_log.size() > 1 ? gnt_log[1] : -1, 1);
        chk("t3_src1_bytes", out_data.size(), 5);

        // Source 1 underruns after 5 of 20 bytes.
        do_reset();
        arm(1, 20, 5, 1'b0, 0, 0);
        wait_idle(400);
        chk("t4_bytes", out_data.size(), 6);
        chk("t4_byte4", out_data[4], 8'h44);
        chk("t4_term_data", out_data[5], 0);
        chk("t4_term_flags", out_flags[5], 1);
        chk("t4_err_pulses", err_cnt, 1);

        // Noisy non-grantee source 2, then a single-byte frame from source 0.
        do_reset();
        c_noise[2] = 1'b1;
        arm(0, 8, -1, 1'b0, 0, 0);
        wait_idle(400);
        arm(0, 1, -1, 1'b0, 0, 0);
        wait_idle(400);
        chk("t5_bytes", out_data.size(), 9);
        bad = 0;
        for (int i = 0; i < 8; i++) if (out_data[i] != i) bad++;
        chk("t5_data_seq", bad, 0);
        chk("t5_single_flags", out_flags[8], 3);
        c_noise[2] = 1'b0;

        // Reset in the middle of a frame.
        do_reset();
        arm(0, 30, -1, 1'b0, 0, 0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1; c_clr++;
        #1;
        chk("t6_rst_valid", int'(tx_valid), 0);
        chk("t6_rst_gnt", int'(gnt), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_data", int'(tx_data), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_logs();
        arm(2, 4, -1, 1'b0, 0, 0); arm(1, 4, -1, 1'b0, 0, 0);
        wait_idle(400);
        chk("t6_first_grant", gnt_log.size() > 0 ? gnt_log[0] : -1, 1);
        chk("t6_second_grant", gnt_log.size() > 1 ? gnt_log[1] : -1, 2);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++) begin
                int len, stall;
                c_noise[k] = 1'($urandom);
                if ($urandom_range(0, 2) != 0) begin
                    len = $urandom_range(1, 12);
                    stall = (len >= 2 && $urandom_range(0, 6) == 0) ? $urandom_range(1, len - 1) : -1;
                    if ($urandom_range(0, 9) == 0)
                        arm(k, len, -1, 1'b1, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 80) : 0, 0);
                    else
                        arm(k, len, stall, 1'b0, 0, $urandom_range(0, 1));
                end
            end
            wait_idle(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
